register_file_sb: RTL

Two-read/one-write 32 x 32-bit MIPS register file with an integrated pending-write scoreboard. It sits directly downstream of the 4-to-1 write-back select mux, which feeds `writeData`, and directly upstream of the ID-stage operand logic. It provides bypassed operand reads and per-register busy/stall indication so the pipeline holds dependent instructions until their producer writes back.

---
 rtl/register_file_sb.sv | 119 +++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// 32 x WIDTH two-read/one-write MIPS register file with write-back bypass and a
// per-register pending-write scoreboard that drives operand busy/stall.
module register_file_sb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       readReg1,
  input  logic [4:0]       readReg2,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2,
  input  logic             regWrite,
  input  logic [4:0]       writeReg,
  input  logic [WIDTH-1:0] writeData,
  input  logic             issueValid,
  input  logic [4:0]       issueReg,
  output logic             busy1,
  output logic             busy2,
  output logic             stall,
  output logic             scoreErr
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] regs_q [1:31];
  logic [CNT_W-1:0] cnt_q  [1:31];
  logic [CNT_W-1:0] cnt_d  [1:31];
  logic             score_err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_rd1_s;
  logic [CNT_W-1:0] cnt_rd2_s;

  // Scoreboard next state: issue increments, completion decrements, both cancel.
  always_comb begin
    err_d = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({issueValid && (issueReg == 5'(i)), regWrite && (writeReg == 5'(i))})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt_q[i] == CNT_ZERO) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Register array, pending counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
        cnt_q[i]  <= CNT_ZERO;
      end
      score_err_q <= 1'b0;
    end else begin
      if (regWrite && (writeReg != 5'd0)) begin
        regs_q[writeReg] <= writeData;
      end
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      score_err_q <= score_err_q | err_d;
    end
  end

  // Bypassed operand reads; $0 and reset force zero.
  always_comb begin
    if (reset || (readReg1 == 5'd0)) begin
      readData1 = {WIDTH{1'b0}};
    end else if (regWrite && (writeReg == readReg1)) begin
      readData1 = writeData;
    end else begin
      readData1 = regs_q[readReg1];
    end
    if (reset || (readReg2 == 5'd0)) begin
      readData2 = {WIDTH{1'b0}};
    end else if (regWrite && (writeReg == readReg2)) begin
      readData2 = writeData;
    end else begin
      readData2 = regs_q[readReg2];
    end
  end

  // Busy unless the last outstanding write is completing right now.
  always_comb begin
    if (readReg1 == 5'd0) begin
      cnt_rd1_s = CNT_ZERO;
    end else begin
      cnt_rd1_s = cnt_q[readReg1];
    end
    if (readReg2 == 5'd0) begin
      cnt_rd2_s = CNT_ZERO;
    end else begin
      cnt_rd2_s = cnt_q[readReg2];
    end
    busy1 = (cnt_rd1_s != CNT_ZERO) &&
            !((cnt_rd1_s == CNT_ONE) && regWrite && (writeReg == readReg1));
    busy2 = (cnt_rd2_s != CNT_ZERO) &&
            !((cnt_rd2_s == CNT_ONE) && regWrite && (writeReg == readReg2));
    stall = busy1 | busy2;
  end

  assign scoreErr = score_err_q;

endmodule
